// File: rtl/mem_access_ctrl_if.sv
// Host request/response and 8x8 bit-cell array bus of mem_access_ctrl.
// Handshake: a request is taken at a rising edge where ready=1 and req=1; done pulses for one cycle when it completes.
interface mem_access_ctrl_if;
  logic       req;
  logic       we;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic       done;
  logic [7:0] rdata;
  logic [7:0] row_sel;
  logic       rw;
  logic [7:0] din;
  logic [7:0] dout;

  modport slave (
    input  req, we, addr, wdata, dout,
    output ready, done, rdata, row_sel, rw, din
  );

  modport master (
    output req, we, addr, wdata, dout,
    input  ready, done, rdata, row_sel, rw, din
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-access controller for an 8x8 bit-cell array: one host read or write at a time,
// with a fixed row-select hold per operation and a one-cycle done pulse.
module mem_access_ctrl #(
  parameter int unsigned WR_HOLD   = 2,
  parameter int unsigned RD_SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_access_ctrl_if.slave     bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] WR_LOAD = 4'(WR_HOLD - 1);
  localparam logic [3:0] RD_LOAD = 4'(RD_SETTLE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [2:0] row;
  logic [7:0] din_q;
  logic [7:0] rdata_q;
  logic       ready;
  logic       accept;
  logic       read_last;

  // ready is gated by rst so the host never sees an idle controller while reset is held
  assign ready     = (state == IDLE) && !rst;
  assign accept    = ready && bus.req;
  assign read_last = (state == READ) && (cnt == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      row     <= 3'd0;
      din_q   <= 8'd0;
      rdata_q <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        row <= bus.addr;
        if (bus.we) din_q <= bus.wdata;
      end
      if (read_last) rdata_q <= bus.dout;
    end
  end

  // cnt counts down the remaining cycles of WRITE/READ; zero means this is the last one
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = 4'd0;
        if (accept) begin
          if (bus.we) begin
            state_nxt = WRITE;
            cnt_nxt   = WR_LOAD;
          end else begin
            state_nxt = READ;
            cnt_nxt   = RD_LOAD;
          end
        end
      end
      WRITE, READ: begin
        if (cnt == 4'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // rw and row_sel both derive from state, so rw only moves on edges where row_sel is zero before or after
  assign bus.ready   = ready;
  assign bus.done    = (state == DONE);
  assign bus.row_sel = ((state == WRITE) || (state == READ)) ? (8'd1 << row) : 8'd0;
  assign bus.rw      = (state == WRITE);
  assign bus.din     = din_q;
  assign bus.rdata   = rdata_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: array model on the bit-cell bus, scoreboard of expected accesses,
// directed cases plus random traffic and a mid-write reset.
module tb_mem_access_ctrl;

  localparam int unsigned WR_HOLD   = 2;
  localparam int unsigned RD_SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.WR_HOLD(WR_HOLD), .RD_SETTLE(RD_SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // {we, addr[2:0], data[7:0]}; data is wdata for writes, expected read word for reads
  logic [11:0] exp_q[$];
  logic [7:0]  mem_exp [8] = '{default: 8'h00};
  logic [7:0]  arr     [8] = '{default: 8'h00};
  logic [7:0]  junk = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sel_idx(input logic [7:0] s);
    for (int i = 0; i < 8; i++) if (s[i]) return i;
    return 0;
  endfunction

  // Bit-cell array: cells store din on a selected write; the column bus carries junk when no row reads
  always @(posedge clk) if (bus.row_sel != 8'd0 && bus.rw) arr[sel_idx(bus.row_sel)] <= bus.din;
  always @(negedge clk) junk <= 8'($urandom);
  assign bus.dout = (bus.row_sel != 8'd0 && !bus.rw) ? arr[sel_idx(bus.row_sel)] : junk;

  // Monitor / scoreboard
  logic [7:0]  prev_sel = 8'd0;
  logic        prev_rw = 1'b0;
  logic [7:0]  prev_rdata = 8'd0;
  logic [7:0]  prev_din = 8'd0;
  logic        prev_rst = 1'b1;
  int          acc_n = 0;
  int          sel_bad = 0;
  logic [7:0]  acc_sel = 8'd0;
  logic        acc_rw = 1'b0;
  logic [7:0]  acc_din = 8'd0;
  logic        exp_ready = 1'b0;
  logic [7:0]  last_rd = 8'd0;
  logic [11:0] e;
  logic [7:0]  one = 8'd1;

  always @(negedge clk) begin
    if (rst) begin
      acc_n     = 0;
      sel_bad   = 0;
      exp_ready = 1'b0;
      last_rd   = 8'd0;
    end else begin
      check("onehot", 32'($onehot0(bus.row_sel)), 1);
      if (bus.row_sel != 8'd0) check("ready_busy", bus.ready, 0);
      if (!prev_rst) begin
        if (bus.rw != prev_rw) check("rw_edge", (prev_sel == 8'd0 || bus.row_sel == 8'd0), 1);
        if (bus.rdata != prev_rdata) check("rdata_hold", (prev_sel != 8'd0 && !prev_rw), 1);
        if (bus.din != prev_din) check("din_hold", (bus.row_sel != 8'd0 && bus.rw && prev_sel == 8'd0), 1);
      end
      if (exp_ready) begin
        check("ready_after_done", bus.ready, 1);
        exp_ready = 1'b0;
      end
      if (bus.row_sel != 8'd0) begin
        if (acc_n == 0) begin
          acc_sel = bus.row_sel;
          acc_rw  = bus.rw;
          acc_din = bus.din;
        end else if (bus.row_sel != acc_sel || bus.rw != acc_rw || (bus.rw && bus.din != acc_din)) begin
          sel_bad++;
        end
        acc_n++;
      end
      if (bus.done) begin
        check("ready_in_done", bus.ready, 0);
        check("done_follows_access", (prev_sel != 8'd0), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("row_sel", acc_sel, one << e[10:8]);
          check("rw", acc_rw, e[11]);
          check("hold_cycles", acc_n, e[11] ? WR_HOLD : RD_SETTLE);
          check("access_stable", sel_bad, 0);
          if (e[11]) begin
            check("din", acc_din, e[7:0]);
            check("rdata_after_write", bus.rdata, last_rd);
          end else begin
            check("rdata", bus.rdata, e[7:0]);
            last_rd = e[7:0];
          end
        end
        acc_n     = 0;
        sel_bad   = 0;
        exp_ready = 1'b1;
      end
    end
    prev_sel   = bus.row_sel;
    prev_rw    = bus.rw;
    prev_rdata = bus.rdata;
    prev_din   = bus.din;
    prev_rst   = rst;
  end

  // Driver tasks
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) check("ready_timeout", 0, 1);
  endtask

  task automatic drive_req(input logic w, input logic [2:0] a, input logic [7:0] d);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    if (w) begin
      mem_exp[a] = d;
      exp_q.push_back({1'b1, a, d});
    end else begin
      exp_q.push_back({1'b0, a, mem_exp[a]});
    end
  endtask

  task automatic do_op(input logic w, input logic [2:0] a, input logic [7:0] d, input bit flood);
    wait_ready();
    if (!bus.ready) return;
    drive_req(w, a, d);
    @(posedge clk);
    if (!flood) begin
      @(negedge clk);
      bus.req   = 1'b0;
      bus.we    = 1'($urandom_range(0, 1));
      bus.addr  = 3'($urandom_range(0, 7));
      bus.wdata = 8'($urandom_range(0, 255));
    end else begin
      // keep hammering new requests while busy; drop req the moment ready returns
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.ready) begin
          bus.req = 1'b0;
          break;
        end
        bus.req   = 1'b1;
        bus.we    = 1'($urandom_range(0, 1));
        bus.addr  = 3'($urandom_range(0, 7));
        bus.wdata = 8'($urandom_range(0, 255));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 3'd0;
    bus.wdata = 8'd0;

    // Reset state
    #1;
    check("rst_ready", bus.ready, 0);
    check("rst_done", bus.done, 0);
    check("rst_row_sel", bus.row_sel, 0);
    check("rst_rw", bus.rw, 0);
    check("rst_din", bus.din, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_state", state_dbg, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", bus.ready, 1);

    // Directed accesses
    do_op(1'b1, 3'd3, 8'hA5, 1'b0);
    do_op(1'b0, 3'd3, 8'h00, 1'b0);
    do_op(1'b1, 3'd0, 8'hFF, 1'b0);
    do_op(1'b1, 3'd7, 8'h00, 1'b0);
    do_op(1'b0, 3'd0, 8'h00, 1'b0);
    do_op(1'b0, 3'd7, 8'h00, 1'b0);
    do_op(1'b1, 3'd4, 8'h96, 1'b1);
    do_op(1'b0, 3'd4, 8'h00, 1'b1);
    do_op(1'b1, 3'd4, 8'h69, 1'b0);
    do_op(1'b0, 3'd4, 8'h00, 1'b0);

    // Random traffic
    for (int i = 0; i < 30; i++) begin
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 3) == 0));
    end

    // Reset in the second WRITE cycle
    do_op(1'b1, 3'd3, 8'h5C, 1'b0);
    do_op(1'b0, 3'd3, 8'h00, 1'b0);
    wait_ready();
    check("rdata_before_abort", bus.rdata, 8'h5C);
    drive_req(1'b1, 3'd6, 8'h3E);
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    check("abort_row_sel_pre", bus.row_sel, 8'h40);
    check("abort_rw_pre", bus.rw, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_row_sel", bus.row_sel, 0);
    check("abort_rw", bus.rw, 0);
    check("abort_rdata", bus.rdata, 0);
    check("abort_done", bus.done, 0);
    check("abort_ready", bus.ready, 0);
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    check("abort_hold_row_sel", bus.row_sel, 0);
    check("abort_hold_done", bus.done, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after", bus.ready, 1);
    check("abort_state", state_dbg, 0);
    check("abort_no_done", bus.done, 0);

    do_op(1'b1, 3'd2, 8'hC3, 1'b0);
    do_op(1'b0, 3'd6, 8'h00, 1'b0);
    do_op(1'b0, 3'd2, 8'h00, 1'b0);
    do_op(1'b1, 3'd2, 8'h11, 1'b1);

    // Drain
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("final_ready", bus.ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
